// File: rtl/kim_fifo_top.sv
// kim_fifo_top: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on the producer (s_*) and consumer (m_*) sides.
// Optional status ports (fifo_count, fifo_full, fifo_empty) are present only
// when the macro KIM_FIFO_STATUS_EN is defined.
module kim_fifo_top #(
  parameter int FIFO_DATA_LENGTH = 32,
  parameter int FIFO_DATA_DEPTH  = 4,
  parameter int FIFO_LOG2_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [FIFO_DATA_LENGTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [FIFO_DATA_LENGTH-1:0] m_data
`ifdef KIM_FIFO_STATUS_EN
  ,
  output logic [FIFO_LOG2_DEPTH:0]    fifo_count,
  output logic                        fifo_full,
  output logic                        fifo_empty
`endif
);

  localparam int PW = FIFO_LOG2_DEPTH + 1;

  logic [FIFO_DATA_LENGTH-1:0] mem [FIFO_DATA_DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic                        full;
  logic                        empty;
  logic                        do_wr;
  logic                        do_rd;

  // Status decode from registered pointers only; the MSB is the wrap bit.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[FIFO_LOG2_DEPTH-1:0] == rd_ptr[FIFO_LOG2_DEPTH-1:0]) &&
            (wr_ptr[FIFO_LOG2_DEPTH] != rd_ptr[FIFO_LOG2_DEPTH]);
    s_ready = !full;
    m_valid = !empty;
    do_wr   = s_valid && !full;
    do_rd   = m_ready && !empty;
    m_data  = mem[rd_ptr[FIFO_LOG2_DEPTH-1:0]];
  end

  // Pointer update; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wr_ptr[FIFO_LOG2_DEPTH-1:0]] <= s_data;
  end

`ifdef KIM_FIFO_STATUS_EN
  // Occupancy and flags exported for monitoring.
  always_comb begin
    fifo_count = wr_ptr - rd_ptr;
    fifo_full  = full;
    fifo_empty = empty;
  end
`endif

endmodule

// File: tb/tb_kim_fifo_top.sv
// tb_kim_fifo_top: self-checking bench for kim_fifo_top (depth 4, 32-bit).
// Table-driven vectors, hand-written corner sequences and a randomized
// ordering run checked against a queue-based reference model.
module tb_kim_fifo_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
`ifdef KIM_FIFO_STATUS_EN
  logic [2:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  kim_fifo_top #(
    .FIFO_DATA_LENGTH(32),
    .FIFO_DATA_DEPTH(4),
    .FIFO_LOG2_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
`ifdef KIM_FIFO_STATUS_EN
    ,
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic        chk_d;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic sv, logic [31:0] sd, logic mr,
                              logic e_sr, logic e_mv, logic chk_d, logic [31:0] e_d);
    vec_t v;
    v.rst = r; v.sv = sv; v.sd = sd; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.chk_d = chk_d; v.e_d = e_d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive inputs, then let one rising edge pass and settle outputs.
  task automatic step(input logic r, input logic sv, input logic [31:0] sd, input logic mr);
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    @(posedge clk);
    #1;
  endtask

  int q[$];
  int next_in;
  int exp_out;
  int cyc;
  bit w, rd;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #1;

    // Fill/stall, drain, full-with-simultaneous-request vectors.
    tbl.push_back(mk(1, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 0, 1, 1, 1, 10));
    tbl.push_back(mk(0, 1, 11, 0, 1, 1, 1, 10));
    tbl.push_back(mk(0, 1, 12, 0, 1, 1, 1, 10));
    tbl.push_back(mk(0, 1, 13, 0, 0, 1, 1, 10));
    tbl.push_back(mk(0, 1, 99, 0, 0, 1, 1, 10));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 11));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 12));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 13));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 20, 0, 1, 1, 1, 20));
    tbl.push_back(mk(0, 1, 21, 0, 1, 1, 1, 20));
    tbl.push_back(mk(0, 1, 22, 0, 1, 1, 1, 20));
    tbl.push_back(mk(0, 1, 23, 0, 0, 1, 1, 20));
    tbl.push_back(mk(0, 1, 24, 1, 1, 1, 1, 21));
    tbl.push_back(mk(0, 1, 24, 0, 0, 1, 1, 21));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 22));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 23));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 24));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr);
      check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_sr));
      check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
      if (tbl[i].chk_d) check($sformatf("vec%0d m_data", i), m_data, tbl[i].e_d);
`ifdef KIM_FIFO_STATUS_EN
      check($sformatf("vec%0d fifo_empty", i), 32'(fifo_empty), 32'(!tbl[i].e_mv));
      check($sformatf("vec%0d fifo_full", i), 32'(fifo_full), 32'(!tbl[i].e_sr));
`endif
    end

    // Wrap: 12 words streamed with both sides always ready.
    step(1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 32'(100 + k), 1);
      check($sformatf("wrap%0d m_valid", k), 32'(m_valid), 32'd1);
      check($sformatf("wrap%0d m_data", k), m_data, 32'(100 + k));
    end
    step(0, 0, 0, 1);
    check("wrap_end m_valid", 32'(m_valid), 32'd0);

    // Reset mid-operation with three words stored.
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    step(0, 1, 3, 0);
`ifdef KIM_FIFO_STATUS_EN
    check("midrst count_before", 32'(fifo_count), 32'd3);
`endif
    check("midrst head_before", m_data, 32'd1);
    step(1, 1, 77, 1);
    check("midrst m_valid", 32'(m_valid), 32'd0);
    check("midrst s_ready", 32'(s_ready), 32'd1);
`ifdef KIM_FIFO_STATUS_EN
    check("midrst count_after", 32'(fifo_count), 32'd0);
    check("midrst empty_after", 32'(fifo_empty), 32'd1);
    check("midrst full_after", 32'(fifo_full), 32'd0);
`endif
    step(0, 1, 55, 0);
    check("midrst m_valid_55", 32'(m_valid), 32'd1);
    check("midrst m_data_55", m_data, 32'd55);

    // Random ordering run against a queue model.
    step(1, 0, 0, 0);
    q.delete();
    next_in = 0;
    exp_out = 0;
    cyc = 0;
    while (exp_out < 1000 && cyc < 20000) begin
      check("rnd s_ready", 32'(s_ready), 32'(q.size() < 4));
      check("rnd m_valid", 32'(m_valid), 32'(q.size() > 0));
      rst     = 1'b0;
      s_valid = ($urandom % 2 == 1) && (next_in < 1000);
      s_data  = 32'(next_in);
      m_ready = ($urandom % 2 == 1);
      w  = s_valid && (q.size() < 4);
      rd = m_ready && (q.size() > 0);
      if (rd) check($sformatf("rnd out%0d", exp_out), m_data, 32'(exp_out));
      @(posedge clk);
      #1;
      if (rd) begin
        void'(q.pop_front());
        exp_out++;
      end
      if (w) begin
        q.push_back(next_in);
        next_in++;
      end
      cyc++;
    end
    n_checks++;
    if (exp_out == 1000) n_pass++;
    else $display("FAIL rnd timeout: got %0d outputs, expected 1000", exp_out);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
